pcm_mem_arbiter: RTL and testbench
==================================

# pcm_mem_arbiter

Parametrised N-channel arbiter sharing the single PCM on-chip memory port (Avalon-MM style, fixed read latency) among the SRAM-style memory ports of the PCM CPU array. It is the scalable successor to hard-wiring one CPU per memory: channel count, address/data widths and memory read latency are parameters. Arbitration is round-robin with byte-lane writes and out-of-range detection. It sits between the `CPU` instances and the `pcm_mem_mm_*` port of the Nios system.

## Interface
- `N_CH`, 4: number of CPU channels (2..16)
- `ADDR_W`, 16: CPU address width
- `DATA_W`, 16: data width (even; two byte lanes when 16)
- `MEM_AW`, 11: memory word-address width (≤ `ADDR_W`)
- `RD_LAT`, 1: memory read latency in cycles (1..4)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `cpu_ce_n`  in  N_CH  per-channel chip enable (active low)
- `cpu_oe_n`  in  N_CH  per-channel read strobe (active low)
- `cpu_we_n`  in  N_CH  per-channel write strobe (active low)
- `cpu_ub_n`, `cpu_lb_n`  in  N_CH each  upper/lower byte enables (active low)
- `cpu_addr`  in  N_CH×ADDR_W  per-channel address
- `cpu_wdata`  in  N_CH×DATA_W  per-channel write data
- `cpu_rdata`  out  N_CH×DATA_W  per-channel registered read data
- `cpu_ready`  out  N_CH  one-cycle completion pulse
- `cpu_err`  out  N_CH  out-of-range flag, valid with `cpu_ready`
- `mem_address`  out  MEM_AW; `mem_chipselect`, `mem_write`, `mem_clken`  out  1 each
- `mem_byteenable`  out  DATA_W/8; `mem_writedata`  out  DATA_W; `mem_readdata`  in  DATA_W
- `grant`  out  N_CH  one-hot owner of the current access, 0 in IDLE

## Operation
- Request on channel i: `cpu_ce_n[i]`=0 and (`cpu_oe_n[i]`=0 or `cpu_we_n[i]`=0). Held as a level until `cpu_ready[i]`. Dropped no later than the cycle after `ready`.
- Both strobes low means write.
- FSM states: IDLE → ISSUE → (read: WAIT) → RESP → IDLE.
- **IDLE:** if any request is present, pick the winner round-robin from pointer `ptr`. Register `grant`, address, data and byte enables, then go to ISSUE.
- **ISSUE:** one cycle with `mem_chipselect`=1 and `mem_write`=write.
  - `mem_byteenable` = {~ub_n, ~lb_n} for writes; all ones for reads.
  - `mem_address` = `cpu_addr[MEM_AW-1:0]`.
  - Next state: writes go to RESP; reads go to WAIT.
- **WAIT:** lasts `RD_LAT` cycles. On the last one, capture `mem_readdata` into `cpu_rdata[g]`, then go to RESP.
- **RESP:** `cpu_ready[g]`=1 for one cycle, `ptr` ← (g+1) mod N_CH, then IDLE.
- **Out-of-range:** `cpu_addr[ADDR_W-1:MEM_AW]` ≠ 0.
  - ISSUE drives `mem_chipselect`=0 and the FSM goes straight to RESP.
  - `cpu_err[g]`=1 with `ready`; read data returned as 0.
- **Empty write:** a write with both `ub_n`/`lb_n` high issues no memory cycle (chipselect 0) and completes with `err`=0.
- `cpu_rdata[i]` holds its last value until that channel's next read completes.
- Requests arriving while busy wait. There is no preemption and no starvation: each requester is served within N_CH accesses.
- `mem_clken` = 1 whenever out of reset.

## Timing
- Reset (async assert, sync release) gives: state IDLE, `ptr`=0, and all outputs 0 (`grant`, `cpu_ready`, `cpu_err`, `cpu_rdata`, `mem_*`, `mem_clken` included).
- Request first seen in IDLE at cycle t:
  - ISSUE at t+1.
  - Write `ready` at t+2.
  - Read `ready` at t+2+RD_LAT (t+3 for default).
- Per-access occupancy: write 3 cycles, read 3+RD_LAT (IDLE included).
- Simultaneous requests in the same IDLE cycle: lowest index at or after `ptr` wins (wraps past N_CH-1 to 0).
- Reset mid-access: return to IDLE immediately. An in-flight write may or may not have committed. No `ready` is produced for the aborted access.
- A channel re-requesting in the IDLE cycle right after its own RESP is legal. It gets lowest priority because of the `ptr` update.

## Structure
- Package `pcm_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), default parameter constants, and a `byte_en_t` typedef.
- Sub-module `rr_arbiter`: combinational one-hot pick from request vector plus `ptr`, parametrised by N_CH.
- Top level holds the FSM, the latency counter, and the request/response registers.

## Test plan
- Single read, ch2, addr 0x0010, memory preloaded 0xBEEF → ISSUE at t+1 with address 0x010; `cpu_ready[2]` at t+3; `cpu_rdata[2]`=0xBEEF; `err`=0.
- Write ch1, addr 0x07FF, data 0x1234, ub_n=0, lb_n=1 → `mem_byteenable`=2'b10, `mem_writedata`=0x1234, `ready[1]` at t+2; readback gives 0x12xx.
- All four channels requesting reads continuously from reset → grant order 0,1,2,3,0,1; one `ready` every 4 cycles.
- Ch3 read addr 0x0800 (out of range, MEM_AW=11) → no chipselect; `ready[3]` and `err[3]` together; `rdata[3]`=0.
- RD_LAT=3 build, ch0 read → `ready[0]` at t+5 with correct data.
- Reset asserted during WAIT → all outputs 0 within the same cycle; after release, a ch1 request is granted first (`ptr`=0, only requester).

Source files
------------

// File: rtl/pcm_mem_arbiter_pkg.sv
// Shared types and default build constants for the PCM memory arbiter.
package pcm_arb_pkg;

   localparam int unsigned DEF_N_CH   = 4;
   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_MEM_AW = 11;
   localparam int unsigned DEF_RD_LAT = 1;

   // Access sequencer states
   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } arb_state_t;

   // Byte-lane enables for the default data width (bit 1 = upper byte)
   typedef logic [DEF_DATA_W/8-1:0] byte_en_t;

endpackage

// File: rtl/pcm_mem_arbiter_if.sv
// Avalon-MM style on-chip memory port with a fixed read latency.
interface pcm_mem_if #(
   parameter int unsigned MEM_AW = pcm_arb_pkg::DEF_MEM_AW,
   parameter int unsigned DATA_W = pcm_arb_pkg::DEF_DATA_W
);
   localparam int unsigned BE_W = (DATA_W / 8 > 0) ? DATA_W / 8 : 1;

   logic [MEM_AW-1:0] address;
   logic              chipselect;
   logic              write;
   logic              clken;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (
      output address, chipselect, write, clken, byteenable, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write, clken, byteenable, writedata,
      output readdata
   );

endinterface

// File: rtl/pcm_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping to 0.
module rr_arbiter
   import pcm_arb_pkg::*;
#(
   parameter int unsigned N_CH = DEF_N_CH
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] ptr,
   output logic [N_CH-1:0]         gnt
);

   logic found;

   // Scan the upper segment [ptr..N_CH-1] first, then fall back to the lowest index overall
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && req[i] && (i >= 32'(ptr))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcm_mem_arbiter.sv
// N-channel round-robin arbiter sharing one fixed-latency memory port among SRAM-style CPU ports.
module pcm_mem_arbiter
   import pcm_arb_pkg::*;
#(
   parameter int unsigned N_CH   = DEF_N_CH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned MEM_AW = DEF_MEM_AW,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CH-1:0]              cpu_ce_n,
   input  logic [N_CH-1:0]              cpu_oe_n,
   input  logic [N_CH-1:0]              cpu_we_n,
   input  logic [N_CH-1:0]              cpu_ub_n,
   input  logic [N_CH-1:0]              cpu_lb_n,
   input  logic [N_CH-1:0][ADDR_W-1:0]  cpu_addr,
   input  logic [N_CH-1:0][DATA_W-1:0]  cpu_wdata,
   output logic [N_CH-1:0][DATA_W-1:0]  cpu_rdata,
   output logic [N_CH-1:0]              cpu_ready,
   output logic [N_CH-1:0]              cpu_err,
   output logic [N_CH-1:0]              grant,
   pcm_mem_if.master                    mem
);

   localparam int unsigned PTR_W = $clog2(N_CH);
   localparam int unsigned BE_W  = (DATA_W / 8 > 0) ? DATA_W / 8 : 1;

   arb_state_t        state_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  g_q;
   logic              wr_q;
   logic              oor_q;
   logic [2:0]        lat_q;

   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   pick;
   logic [PTR_W-1:0]  win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic              win_wr;
   logic              win_oor;
   logic [BE_W-1:0]   win_be;
   logic              win_go;

   // Per-channel request level; both strobes low counts as a write
   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         req[i] = ~cpu_ce_n[i] & (~cpu_oe_n[i] | ~cpu_we_n[i]);
      end
   end

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_rr (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick)
   );

   // Decode the winner: index, range check, lane enables, and whether a memory cycle is needed
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (pick[i]) win_idx = PTR_W'(i);
      end
      win_addr = cpu_addr[win_idx];
      win_wr   = ~cpu_we_n[win_idx];
      win_oor  = |(win_addr >> MEM_AW);
      win_be   = '0;
      for (int unsigned l = 0; l < BE_W; l++) begin
         if (BE_W == 1) begin
            win_be[l] = ~(cpu_ub_n[win_idx] & cpu_lb_n[win_idx]);
         end else if (l >= BE_W / 2) begin
            win_be[l] = ~cpu_ub_n[win_idx];
         end else begin
            win_be[l] = ~cpu_lb_n[win_idx];
         end
      end
      // Out-of-range accesses and writes with no lanes enabled never touch memory
      win_go = ~win_oor & ~(win_wr & (win_be == '0));
   end

   // Access sequencer with registered memory-side and CPU-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         ptr_q           <= '0;
         g_q             <= '0;
         wr_q            <= 1'b0;
         oor_q           <= 1'b0;
         lat_q           <= '0;
         grant           <= '0;
         cpu_ready       <= '0;
         cpu_err         <= '0;
         cpu_rdata       <= '0;
         mem.address     <= '0;
         mem.chipselect  <= 1'b0;
         mem.write       <= 1'b0;
         mem.clken       <= 1'b0;
         mem.byteenable  <= '0;
         mem.writedata   <= '0;
      end else begin
         mem.clken <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (|req) begin
                  state_q        <= StIssue;
                  grant          <= pick;
                  g_q            <= win_idx;
                  wr_q           <= win_wr;
                  oor_q          <= win_oor;
                  mem.address    <= win_addr[MEM_AW-1:0];
                  mem.writedata  <= cpu_wdata[win_idx];
                  mem.byteenable <= win_wr ? win_be : '1;
                  mem.chipselect <= win_go;
                  mem.write      <= win_wr & win_go;
               end
            end
            StIssue: begin
               mem.chipselect <= 1'b0;
               mem.write      <= 1'b0;
               if (wr_q || oor_q) begin
                  state_q        <= StResp;
                  cpu_ready[g_q] <= 1'b1;
                  cpu_err[g_q]   <= oor_q;
                  if (!wr_q) cpu_rdata[g_q] <= '0;
               end else begin
                  state_q <= StWait;
                  lat_q   <= 3'(RD_LAT - 1);
               end
            end
            StWait: begin
               if (lat_q == '0) begin
                  state_q        <= StResp;
                  cpu_rdata[g_q] <= mem.readdata;
                  cpu_ready[g_q] <= 1'b1;
                  cpu_err[g_q]   <= 1'b0;
               end else begin
                  lat_q <= lat_q - 3'd1;
               end
            end
            StResp: begin
               state_q   <= StIdle;
               cpu_ready <= '0;
               cpu_err   <= '0;
               grant     <= '0;
               // Served channel drops to lowest priority
               ptr_q     <= (32'(g_q) == N_CH - 1) ? '0 : g_q + 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Directed bench: table of single-channel accesses plus arbitration, latency and reset sequences.
module tb_pcm_mem_arbiter;
   import pcm_arb_pkg::*;

   logic clk;
   logic reset;

   // Default build (RD_LAT = 1)
   logic [3:0]       ce_n, oe_n, we_n, ub_n, lb_n;
   logic [3:0][15:0] addr, wdata, rdata;
   logic [3:0]       ready, err, grant;
   pcm_mem_if #(.MEM_AW(11), .DATA_W(16)) mem_bus ();

   // RD_LAT = 3 build
   logic [3:0]       c3_ce_n, c3_oe_n, c3_we_n, c3_ub_n, c3_lb_n;
   logic [3:0][15:0] c3_addr, c3_wdata, c3_rdata;
   logic [3:0]       c3_ready, c3_err, c3_grant;
   pcm_mem_if #(.MEM_AW(11), .DATA_W(16)) mem_bus3 ();

   int total = 0;
   int bad   = 0;

   pcm_mem_arbiter u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_ce_n  (ce_n),
      .cpu_oe_n  (oe_n),
      .cpu_we_n  (we_n),
      .cpu_ub_n  (ub_n),
      .cpu_lb_n  (lb_n),
      .cpu_addr  (addr),
      .cpu_wdata (wdata),
      .cpu_rdata (rdata),
      .cpu_ready (ready),
      .cpu_err   (err),
      .grant     (grant),
      .mem       (mem_bus)
   );

   pcm_mem_arbiter #(
      .RD_LAT (3)
   ) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .cpu_ce_n  (c3_ce_n),
      .cpu_oe_n  (c3_oe_n),
      .cpu_we_n  (c3_we_n),
      .cpu_ub_n  (c3_ub_n),
      .cpu_lb_n  (c3_lb_n),
      .cpu_addr  (c3_addr),
      .cpu_wdata (c3_wdata),
      .cpu_rdata (c3_rdata),
      .cpu_ready (c3_ready),
      .cpu_err   (c3_err),
      .grant     (c3_grant),
      .mem       (mem_bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: byte-lane writes, read data RD_LAT cycles after the issue cycle
   logic [15:0] mem1 [0:2047];
   logic [15:0] rd1;
   always @(posedge clk) begin
      if (mem_bus.chipselect && mem_bus.write) begin
         if (mem_bus.byteenable[1]) mem1[mem_bus.address][15:8] <= mem_bus.writedata[15:8];
         if (mem_bus.byteenable[0]) mem1[mem_bus.address][7:0]  <= mem_bus.writedata[7:0];
      end
      rd1 <= (mem_bus.chipselect && !mem_bus.write) ? mem1[mem_bus.address] : 16'h0;
   end
   assign mem_bus.readdata = rd1;

   logic [15:0] mem3 [0:2047];
   logic [15:0] rd3 [0:2];
   always @(posedge clk) begin
      if (mem_bus3.chipselect && mem_bus3.write) begin
         if (mem_bus3.byteenable[1]) mem3[mem_bus3.address][15:8] <= mem_bus3.writedata[15:8];
         if (mem_bus3.byteenable[0]) mem3[mem_bus3.address][7:0]  <= mem_bus3.writedata[7:0];
      end
      rd3[0] <= (mem_bus3.chipselect && !mem_bus3.write) ? mem3[mem_bus3.address] : 16'h0;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end
   assign mem_bus3.readdata = rd3[2];

   typedef struct {
      logic [1:0]  ch;
      logic        wr;
      logic [15:0] a;
      logic [15:0] wd;
      logic        ubn;
      logic        lbn;
      int          lat;
      logic        cs;
      byte_en_t    be;
      logic [15:0] rd;
      logic        er;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Run one isolated access; called with the DUT idle at a falling edge
   task automatic run_vec(input int idx, input vec_t v);
      int         n;
      logic [3:0] r;
      ce_n[v.ch]  = 1'b0;
      we_n[v.ch]  = ~v.wr;
      oe_n[v.ch]  = v.wr;
      ub_n[v.ch]  = v.ubn;
      lb_n[v.ch]  = v.lbn;
      addr[v.ch]  = v.a;
      wdata[v.ch] = v.wd;
      n = 0;
      r = '0;
      while (r == '0 && n < 30) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk($sformatf("v%0d grant", idx), 64'(grant), 64'(4'b0001 << v.ch));
            chk($sformatf("v%0d chipselect", idx), 64'(mem_bus.chipselect), 64'(v.cs));
            chk($sformatf("v%0d write", idx), 64'(mem_bus.write), 64'(v.cs & v.wr));
            if (v.cs) begin
               chk($sformatf("v%0d address", idx), 64'(mem_bus.address), 64'(v.a[10:0]));
               chk($sformatf("v%0d byteenable", idx), 64'(mem_bus.byteenable), 64'(v.be));
               if (v.wr) chk($sformatf("v%0d writedata", idx), 64'(mem_bus.writedata), 64'(v.wd));
            end
         end
         r = ready;
      end
      chk($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
      chk($sformatf("v%0d ready", idx), 64'(r), 64'(4'b0001 << v.ch));
      chk($sformatf("v%0d err", idx), 64'(err), v.er ? 64'(4'b0001 << v.ch) : 64'(0));
      if (!v.wr) chk($sformatf("v%0d rdata", idx), 64'(rdata[v.ch]), 64'(v.rd));
      ce_n[v.ch] = 1'b1;
      oe_n[v.ch] = 1'b1;
      we_n[v.ch] = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ready(output logic [3:0] r, output int n, output logic [3:0] g1);
      r  = '0;
      n  = 0;
      g1 = '0;
      while (r == '0 && n < 30) begin
         @(negedge clk);
         n++;
         if (n == 1) g1 = grant;
         r = ready;
      end
   endtask

   initial begin
      int         n, cyc, cnt;
      logic [3:0] r, g1;
      int         seen_ch [6];
      int         seen_at [6];

      //              ch   wr    addr     wdata    ubn   lbn  lat cs    be      rdata    err
      vecs[0]  = '{2'd0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000, 1'b0};
      vecs[1]  = '{2'd2, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'hBEEF, 1'b0};
      vecs[2]  = '{2'd1, 1'b1, 16'h07FF, 16'h5678, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000, 1'b0};
      vecs[3]  = '{2'd1, 1'b1, 16'h07FF, 16'h1234, 1'b0, 1'b1, 2, 1'b1, 2'b10, 16'h0000, 1'b0};
      vecs[4]  = '{2'd1, 1'b0, 16'h07FF, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'h1278, 1'b0};
      vecs[5]  = '{2'd3, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'hBEEF, 1'b0};
      vecs[6]  = '{2'd3, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 2'b11, 16'h0000, 1'b1};
      vecs[7]  = '{2'd0, 1'b1, 16'h0005, 16'hA5C3, 1'b0, 1'b0, 2, 1'b1, 2'b11, 16'h0000, 1'b0};
      vecs[8]  = '{2'd2, 1'b1, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 2, 1'b0, 2'b00, 16'h0000, 1'b0};
      vecs[9]  = '{2'd0, 1'b1, 16'h0005, 16'h0011, 1'b1, 1'b0, 2, 1'b1, 2'b01, 16'h0000, 1'b0};
      vecs[10] = '{2'd0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'hA511, 1'b0};
      vecs[11] = '{2'd1, 1'b1, 16'h8000, 16'h9999, 1'b0, 1'b0, 2, 1'b0, 2'b11, 16'h0000, 1'b1};
      vecs[12] = '{2'd1, 1'b0, 16'hF7FF, 16'h0000, 1'b0, 1'b0, 2, 1'b0, 2'b11, 16'h0000, 1'b1};
      vecs[13] = '{2'd1, 1'b0, 16'h07FF, 16'h0000, 1'b0, 1'b0, 3, 1'b1, 2'b11, 16'h1278, 1'b0};

      ce_n = '1; oe_n = '1; we_n = '1; ub_n = '0; lb_n = '0; addr = '0; wdata = '0;
      c3_ce_n = '1; c3_oe_n = '1; c3_we_n = '1; c3_ub_n = '0; c3_lb_n = '0;
      c3_addr = '0; c3_wdata = '0;
      reset = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset grant", 64'(grant), 64'(0));
      chk("reset ready", 64'(ready), 64'(0));
      chk("reset err", 64'(err), 64'(0));
      chk("reset rdata", rdata, 64'(0));
      chk("reset chipselect", 64'(mem_bus.chipselect), 64'(0));
      chk("reset clken", 64'(mem_bus.clken), 64'(0));
      chk("reset address", 64'(mem_bus.address), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("clken after reset", 64'(mem_bus.clken), 64'(1));

      // Single-channel access table
      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
      chk("rdata2 holds", 64'(rdata[2]), 64'(16'hBEEF));
      chk("rdata3 oor zero", 64'(rdata[3]), 64'(0));

      // RD_LAT = 3 build: write then read back on ch0
      c3_ce_n[0] = 1'b0; c3_we_n[0] = 1'b0; c3_addr[0] = 16'h0020; c3_wdata[0] = 16'hC0DE;
      n = 0; r = '0;
      while (r == '0 && n < 30) begin
         @(negedge clk);
         n++;
         r = c3_ready;
      end
      chk("lat3 write latency", 64'(n), 64'(2));
      c3_ce_n[0] = 1'b1; c3_we_n[0] = 1'b1;
      @(negedge clk);
      c3_ce_n[0] = 1'b0; c3_oe_n[0] = 1'b0;
      n = 0; r = '0;
      while (r == '0 && n < 30) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("lat3 chipselect", 64'(mem_bus3.chipselect), 64'(1));
         r = c3_ready;
      end
      chk("lat3 read latency", 64'(n), 64'(5));
      chk("lat3 ready", 64'(r), 64'(4'b0001));
      chk("lat3 rdata", 64'(c3_rdata[0]), 64'(16'hC0DE));
      c3_ce_n[0] = 1'b1; c3_oe_n[0] = 1'b1;

      // All channels reading continuously from reset
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ce_n = '0; oe_n = '0; we_n = '1; addr = {4{16'h0010}};
      cyc = 0; cnt = 0;
      while (cnt < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ready != '0) begin
            seen_ch[cnt] = -1;
            for (int k = 0; k < 4; k++) if (ready == (4'b0001 << k)) seen_ch[cnt] = k;
            seen_at[cnt] = cyc;
            cnt++;
         end
      end
      ce_n = '1;
      chk("rr ready count", 64'(cnt), 64'(6));
      if (cnt == 6) begin
         chk("rr first ready cycle", 64'(seen_at[0]), 64'(3));
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr order %0d", k), 64'(seen_ch[k]), 64'(k % 4));
            if (k > 0) chk($sformatf("rr spacing %0d", k), 64'(seen_at[k] - seen_at[k-1]), 64'(4));
         end
      end
      chk("rr rdata0", 64'(rdata[0]), 64'(16'hBEEF));
      @(negedge clk);

      // Pointer now past ch1: ch3 beats ch0, then ch0 follows after the wrap
      ce_n[0] = 1'b0; ce_n[3] = 1'b0;
      wait_ready(r, n, g1);
      chk("wrap first grant", 64'(g1), 64'(4'b1000));
      chk("wrap first ready", 64'(r), 64'(4'b1000));
      chk("wrap first latency", 64'(n), 64'(3));
      ce_n[3] = 1'b1;
      wait_ready(r, n, g1);
      chk("wrap idle grant", 64'(g1), 64'(0));
      chk("wrap second ready", 64'(r), 64'(4'b0001));
      chk("wrap second latency", 64'(n), 64'(4));
      ce_n[0] = 1'b1;
      @(negedge clk);

      // Reset asserted during WAIT aborts the read
      ce_n[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort grant", 64'(grant), 64'(0));
      chk("abort ready", 64'(ready), 64'(0));
      chk("abort chipselect", 64'(mem_bus.chipselect), 64'(0));
      chk("abort byteenable", 64'(mem_bus.byteenable), 64'(0));
      chk("abort clken", 64'(mem_bus.clken), 64'(0));
      chk("abort rdata", rdata, 64'(0));
      ce_n[2] = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      ce_n[1] = 1'b0; addr[1] = 16'h07FF;
      wait_ready(r, n, g1);
      chk("post reset grant", 64'(g1), 64'(4'b0010));
      chk("post reset ready", 64'(r), 64'(4'b0010));
      chk("post reset latency", 64'(n), 64'(3));
      chk("post reset rdata1", 64'(rdata[1]), 64'(16'h1278));
      chk("post reset rdata2", 64'(rdata[2]), 64'(0));
      ce_n[1] = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
